nn_weight_loader: RTL

Parametrised, runtime-configurable weight loader for the neural-network accelerator. It streams per-neuron weights from beat-wide memory reads into the neuron arrays for an arbitrary number of layers. Each layer's neuron count and weights-per-neuron are latched at start. It adds downstream backpressure, memory addressing, abort and zero-count handling, and sits between the memory fetch unit and the layer weight write ports.

---
 rtl/nn_weight_loader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/nn_weight_loader.sv
// nn_weight_loader: streams per-neuron weights from beat-wide memory reads into the layer write ports.
// Optional build macro WLD_CHECKSUM_EN adds an XOR checksum output over every transferred word.
//   state  | meaning
//   IDLE   | waiting for go
//   NEXT   | pick next non-empty layer, or finish
//   REQ    | fetch one beat from memory
//   STREAM | present beat words to the write port
//   DONE   | one-cycle completion pulse
module nn_weight_loader #(
    parameter int NUM_LAYERS = 3,
    parameter int WORD_W     = 64,
    parameter int BEAT_WORDS = 8,
    parameter int NEURON_W   = 6,
    parameter int WEIGHT_W   = 9,
    parameter int ADDR_W     = 16,
    localparam int LAYER_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int WIDX_W    = $clog2(BEAT_WORDS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           go,
    input  logic                           abort,
    input  logic [NUM_LAYERS*NEURON_W-1:0] cfg_neurons,
    input  logic [NUM_LAYERS*WEIGHT_W-1:0] cfg_weights,
    output logic                           mem_req,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic                           mem_ready,
    input  logic [BEAT_WORDS*WORD_W-1:0]   mem_data,
    output logic [WORD_W-1:0]              weight_bus,
    output logic [LAYER_W-1:0]             layer_sel,
    output logic [NEURON_W-1:0]            neuron_sel,
    output logic [WEIGHT_W-1:0]            weight_sel,
    output logic                           wr_valid,
    input  logic                           wr_ready,
    output logic                           busy,
    output logic                           done
`ifdef WLD_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0]              checksum
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_STREAM, S_NEXT, S_DONE} state_t;

    state_t                       state;
    logic [NEURON_W-1:0]          n_cfg [NUM_LAYERS];
    logic [WEIGHT_W-1:0]          w_cfg [NUM_LAYERS];
    logic [LAYER_W:0]             layer_q;
    logic [WIDX_W-1:0]            word_q;
    logic [BEAT_WORDS*WORD_W-1:0] beat_q;
    logic                         xfer;
    logic                         last_weight;
    logic                         last_neuron;
    logic                         found;
    logic [LAYER_W:0]             found_layer;

    // layer_q carries one extra bit so stepping past the final layer cannot wrap back to layer 0
    assign layer_sel   = layer_q[LAYER_W-1:0];
    assign weight_bus  = beat_q[int'(word_q)*WORD_W +: WORD_W];
    assign xfer        = wr_valid & wr_ready;
    assign last_weight = (weight_sel == w_cfg[layer_sel] - WEIGHT_W'(1));
    assign last_neuron = (neuron_sel == n_cfg[layer_sel] - NEURON_W'(1));

    always_comb begin
        found       = 1'b0;
        found_layer = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (i >= int'(layer_q) && n_cfg[i] != '0 && w_cfg[i] != '0) begin
                found       = 1'b1;
                found_layer = (LAYER_W + 1)'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mem_req    <= 1'b0;
            wr_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            layer_q    <= '0;
            neuron_sel <= '0;
            weight_sel <= '0;
            word_q     <= '0;
            beat_q     <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                n_cfg[i] <= '0;
                w_cfg[i] <= '0;
            end
        end else if (abort) begin
            state      <= S_IDLE;
            mem_req    <= 1'b0;
            wr_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            layer_q    <= '0;
            neuron_sel <= '0;
            weight_sel <= '0;
            word_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        for (int i = 0; i < NUM_LAYERS; i++) begin
                            n_cfg[i] <= cfg_neurons[i*NEURON_W +: NEURON_W];
                            w_cfg[i] <= cfg_weights[i*WEIGHT_W +: WEIGHT_W];
                        end
                        mem_addr   <= '0;
                        layer_q    <= '0;
                        neuron_sel <= '0;
                        weight_sel <= '0;
                        word_q     <= '0;
                        busy       <= 1'b1;
                        state      <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (found) begin
                        layer_q <= found_layer;
                        mem_req <= 1'b1;
                        state   <= S_REQ;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        beat_q   <= mem_data;
                        word_q   <= '0;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        mem_req  <= 1'b0;
                        wr_valid <= 1'b1;
                        state    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (xfer) begin
                        word_q     <= word_q + WIDX_W'(1);
                        weight_sel <= weight_sel + WEIGHT_W'(1);
                        if (last_weight) begin
                            // each neuron starts on a fresh beat; leftover words are dropped
                            weight_sel <= '0;
                            neuron_sel <= neuron_sel + NEURON_W'(1);
                            wr_valid   <= 1'b0;
                            if (last_neuron) begin
                                neuron_sel <= '0;
                                layer_q    <= layer_q + (LAYER_W + 1)'(1);
                                state      <= S_NEXT;
                            end else begin
                                mem_req <= 1'b1;
                                state   <= S_REQ;
                            end
                        end else if (word_q == WIDX_W'(BEAT_WORDS - 1)) begin
                            wr_valid <= 1'b0;
                            mem_req  <= 1'b1;
                            state    <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WLD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (abort) begin
            checksum <= '0;
        end else if (state == S_IDLE && go) begin
            checksum <= '0;
        end else if (state == S_STREAM && xfer) begin
            checksum <= checksum ^ weight_bus;
        end
    end
`endif

endmodule
